// File: rtl/mdu_pkg.sv
// mdu_pkg: RV32M op codes, FSM states and shared constants.
// Imported by mdu_unit and mdu_divider.
package mdu_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam int CNTW = 5;

  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: restoring shift-subtract divider on magnitudes,
// one quotient bit per step; q_nxt/r_nxt show the post-step values.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] q_nxt,
  output logic [XLEN-1:0] r_nxt,
  output logic            last
);

  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [CNTW-1:0] cnt;
  logic [XLEN:0]   sh;
  logic [XLEN:0]   df;

  always_comb begin
    sh    = {rem, quo[XLEN-1]};
    df    = sh - {1'b0, dvs};
    r_nxt = df[XLEN] ? sh[XLEN-1:0] : df[XLEN-1:0];
    q_nxt = {quo[XLEN-2:0], ~df[XLEN]};
    last  = (cnt == CNTW'(XLEN-1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= '0;
    end else if (step) begin
      rem <= r_nxt;
      quo <= q_nxt;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: iterative RV32M multiply/divide unit with registered outputs.
// Divider is built only when MDU_DIV_EN is defined.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd,
  output logic            busy,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  output logic            illegal
);

  state_t state, state_n;

  logic              acc;
  logic              sa, sb;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_n;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mcand;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_res;
  logic [CNTW-1:0]   mcnt;
  logic              mul_last;

  logic              we3_d;
  logic [4:0]        a3_d;
  logic [XLEN-1:0]   wd3_d;
  logic              ill_d;

  assign acc = start && (state == S_IDLE);

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (op)
      OP_MULH, OP_DIV, OP_REM: begin
        sa = 1'b1;
        sb = 1'b1;
      end
      OP_MULHSU: sa = 1'b1;
      default: ;
    endcase
    a_neg = sa & rs1_val[XLEN-1];
    b_neg = sb & rs2_val[XLEN-1];
    a_mag = mag(rs1_val, a_neg);
    b_mag = mag(rs2_val, b_neg);
  end

  // Product's low half starts as the multiplier and shifts out LSB-first.
  always_comb begin
    mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]}
             + (prod[0] ? {1'b0, mcand} : '0);
    prod_n   = {mul_sum, prod[XLEN-1:1]};
    prod_s   = neg_q ? -prod_n : prod_n;
    mul_res  = (op_q == OP_MUL) ? prod_s[XLEN-1:0]
                                : prod_s[2*XLEN-1:XLEN];
    mul_last = (mcnt == CNTW'(XLEN-1));
  end

`ifdef MDU_DIV_EN
  logic [XLEN-1:0] q_nxt, r_nxt, div_res;
  logic            dv_last;
  logic            rneg_q;

  mdu_divider #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (acc && op[2]),
    .step     (state == S_DIV),
    .dividend (a_mag),
    .divisor  (b_mag),
    .q_nxt    (q_nxt),
    .r_nxt    (r_nxt),
    .last     (dv_last)
  );

  assign div_res = op_q[1] ? mag(r_nxt, rneg_q)
                           : mag(q_nxt, neg_q);

  always_ff @(posedge clk) begin
    if (reset)
      rneg_q <= 1'b0;
    else if (acc)
      rneg_q <= a_neg;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!op[2])
            state_n = S_MUL;
`ifdef MDU_DIV_EN
          else if (rs2_val == '0)
            state_n = S_DONE;
          else
            state_n = S_DIV;
`endif
        end
      end
      S_MUL:  if (mul_last) state_n = S_DONE;
`ifdef MDU_DIV_EN
      S_DIV:  if (dv_last) state_n = S_DONE;
`endif
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; they load on entry to DONE.
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3;
    wd3_d = wd3;
    ill_d = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && op[2]) begin
`ifdef MDU_DIV_EN
          if (rs2_val == '0) begin
            we3_d = (rd != '0);
            a3_d  = rd;
            wd3_d = op[1] ? rs1_val : DIV0_Q;
          end
`else
          ill_d = 1'b1;
`endif
        end
      end
      S_MUL: begin
        if (mul_last) begin
          we3_d = (rd_q != '0);
          a3_d  = rd_q;
          wd3_d = mul_res;
        end
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        if (dv_last) begin
          we3_d = (rd_q != '0);
          a3_d  = rd_q;
          wd3_d = div_res;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      we3     <= 1'b0;
      a3      <= '0;
      wd3     <= '0;
      illegal <= 1'b0;
    end else begin
      busy    <= (state_n != S_IDLE);
      we3     <= we3_d;
      a3      <= a3_d;
      wd3     <= wd3_d;
      illegal <= ill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      rd_q  <= '0;
      neg_q <= 1'b0;
      prod  <= '0;
      mcand <= '0;
      mcnt  <= '0;
    end else if (acc) begin
      op_q  <= op;
      rd_q  <= rd;
      neg_q <= a_neg ^ b_neg;
      prod  <= {{XLEN{1'b0}}, b_mag};
      mcand <= a_mag;
      mcnt  <= '0;
    end else if (state == S_MUL) begin
      prod  <= prod_n;
      mcnt  <= mcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench for mdu_unit; directed vectors,
// monitor pops expected writes whenever we3 is seen.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [4:0]  rd = '0;
  logic        busy;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        illegal;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t sbq[$];
  int   cmp = 0;
  int   bad = 0;
  int   cyc = 0;

  mdu_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd      (rd),
    .busy    (busy),
    .we3     (we3),
    .a3      (a3),
    .wd3     (wd3),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && we3 === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_we3", {59'd0, a3}, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("a3", {59'd0, a3}, {59'd0, e.a});
        chk("wd3", {32'd0, wd3}, {32'd0, e.d});
        chk("we3_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic issue(input logic [2:0]  o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0]  r,
                       input logic [31:0] exp,
                       input int          lat);
    int t0;
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    op = o;
    rs1_val = a;
    rs2_val = b;
    rd = r;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    if (r != 0) begin
      e.a = r;
      e.d = exp;
      e.c = t0 + lat;
      sbq.push_back(e);
    end
    chk("illegal_low", {63'd0, illegal}, 64'd0);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall", 64'(cyc), 64'(t0 + lat + 1));
  endtask

  task automatic reset_abort();
    int t0;
    @(negedge clk);
    op = 3'd0;
    rs1_val = 32'd9;
    rs2_val = 32'd9;
    rd = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 9) @(negedge clk);
    op = 3'd3;
    rd = 5'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 19) @(negedge clk);
    chk("busy_pre_reset", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_we3", {63'd0, we3}, 64'd0);
    chk("rst_a3", {59'd0, a3}, 64'd0);
    chk("rst_wd3", {32'd0, wd3}, 64'd0);
    repeat (40) @(negedge clk);
    chk("busy_after_abort", {63'd0, busy}, 64'd0);
  endtask

`ifndef MDU_DIV_EN
  task automatic illegal_req(input logic [2:0] o,
                             input logic [31:0] b);
    @(negedge clk);
    op = o;
    rs1_val = 32'd50;
    rs2_val = b;
    rd = 5'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("illegal_c1", {63'd0, illegal}, 64'd1);
    chk("ill_busy_c1", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    chk("illegal_c2", {63'd0, illegal}, 64'd0);
    chk("ill_busy_c2", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", {63'd0, busy}, 64'd0);
    chk("rst_we30", {63'd0, we3}, 64'd0);
    chk("rst_ill0", {63'd0, illegal}, 64'd0);
    chk("rst_a30", {59'd0, a3}, 64'd0);
    chk("rst_wd30", {32'd0, wd3}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 32);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0, 32);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 32);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 32);
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h1, 32);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 32);
    issue(3'd3, 32'h0001_0000, 32'h0001_0000, 5'd11, 32'h1, 32);
    issue(3'd0, 32'd5, 32'd5, 5'd0, 32'd25, 32);

`ifdef MDU_DIV_EN
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, 32);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, 32);
    issue(3'd5, 32'd123, 32'd0, 5'd14, 32'hFFFF_FFFF, 0);
    issue(3'd7, 32'd123, 32'd0, 5'd15, 32'd123, 0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 32);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0, 32);
    issue(3'd5, 32'd100, 32'd7, 5'd18, 32'd14, 32);
    issue(3'd7, 32'd100, 32'd7, 5'd19, 32'd2, 32);
    issue(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd20, 32'hFFFF_FFFD, 32);
    issue(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd21, 32'd1, 32);
    issue(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd22, 32'hFFFF_FFF9, 0);
`else
    illegal_req(3'd4, 32'd2);
    illegal_req(3'd7, 32'd0);
`endif

    reset_abort();

    issue(3'd0, 32'd3, 32'd4, 5'd1, 32'd12, 32);
    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
